// File: rtl/fp_pkg.sv
// Shared floating-point types and constants for the FP ALU datapath (multiplier, adder).
package fp_pkg;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_QNAN,
        FP_SNAN
    } fp_class_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: positive sign, all-ones exponent, fraction MSB set.
    function automatic logic [63:0] fp_qnan_bits(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic [63:0] fp_inf_bits(input logic sign, input int exp_w, input int man_w);
        return ({63'd0, sign} << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd1) << man_w);
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Normalises a raw significand product and rounds it to nearest-even.
// Shared between the multiplier and adder pipelines.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int P_W   = 2 * MAN_W + 2,
    localparam int SE_W  = EXP_W + 2
) (
    input  logic [P_W-1:0]         sig,
    input  logic signed [SE_W-1:0] exp_in,
    output logic [MAN_W-1:0]       frac,
    output logic signed [SE_W-1:0] exp_out,
    output logic                   inexact
);

    logic [MAN_W-1:0]       kept;
    logic                   guard;
    logic                   sticky;
    logic                   round_up;
    logic [MAN_W+1:0]       rounded;
    logic signed [SE_W-1:0] exp_norm;

    always_comb begin
        // A set MSB means the product landed in [2,4): take one bit more off the bottom.
        if (sig[P_W-1]) begin
            kept     = sig[P_W-2 -: MAN_W];
            guard    = sig[MAN_W];
            sticky   = |sig[MAN_W-1:0];
            exp_norm = exp_in + SE_W'(1);
        end else begin
            kept     = sig[P_W-3 -: MAN_W];
            guard    = sig[MAN_W-1];
            sticky   = |sig[MAN_W-2:0];
            exp_norm = exp_in;
        end
        round_up = guard && (sticky || kept[0]);
        rounded  = {2'b01, kept} + (MAN_W + 2)'(round_up);
        exp_out  = rounded[MAN_W+1] ? exp_norm + SE_W'(1) : exp_norm;
        frac     = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
        inexact  = guard | sticky;
    end

endmodule

// File: rtl/fp_multiplier_pipe.sv
// Three-stage IEEE-754 multiplier: decode, significand multiply, normalise/round/select.
// All stages advance together and freeze while the output is held by downstream.
module fp_multiplier_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic [3:0]   out_flags
);

    localparam int P_W  = 2 * MAN_W + 2;
    localparam int SE_W = EXP_W + 2;
    localparam logic signed [SE_W-1:0] BIAS     = SE_W'(fp_bias(EXP_W));
    localparam logic signed [SE_W-1:0] EXP_MAX  = SE_W'((1 << EXP_W) - 1);
    localparam logic signed [SE_W-1:0] EXP_ZERO = '0;
    localparam logic [W-1:0]           QNAN     = W'(fp_qnan_bits(EXP_W, MAN_W));
    localparam logic [W-1:0]           INF_POS  = W'(fp_inf_bits(1'b0, EXP_W, MAN_W));

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0) begin
            return FP_ZERO;
        end
        if (e == '1) begin
            if (f == '0) begin
                return FP_INF;
            end
            return f[MAN_W-1] ? FP_QNAN : FP_SNAN;
        end
        return FP_NORM;
    endfunction

    logic                   stall;
    logic [EXP_W-1:0]       a_exp, b_exp;
    logic signed [SE_W-1:0] exp_sum;

    logic                   s1_valid, s1_sign;
    fp_class_t              s1_a_class, s1_b_class;
    logic signed [SE_W-1:0] s1_exp;
    logic [MAN_W:0]         s1_sig_a, s1_sig_b;

    logic                   s2_valid, s2_sign;
    fp_class_t              s2_a_class, s2_b_class;
    logic signed [SE_W-1:0] s2_exp;
    logic [P_W-1:0]         s2_prod;

    logic [MAN_W-1:0]       rnd_frac;
    logic signed [SE_W-1:0] rnd_exp;
    logic                   rnd_inexact;
    logic [W-1:0]           res;
    fp_flags_t              flags;
    logic                   any_nan, any_snan, any_inf, any_zero, inf_zero;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign a_exp    = in_a[W-2 -: EXP_W];
    assign b_exp    = in_b[W-2 -: EXP_W];
    assign exp_sum  = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;

    fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .sig     (s2_prod),
        .exp_in  (s2_exp),
        .frac    (rnd_frac),
        .exp_out (rnd_exp),
        .inexact (rnd_inexact)
    );

    // Special operands take priority over anything the rounder produced.
    always_comb begin
        any_nan  = (s2_a_class inside {FP_QNAN, FP_SNAN}) || (s2_b_class inside {FP_QNAN, FP_SNAN});
        any_snan = (s2_a_class == FP_SNAN) || (s2_b_class == FP_SNAN);
        any_inf  = (s2_a_class == FP_INF) || (s2_b_class == FP_INF);
        any_zero = (s2_a_class == FP_ZERO) || (s2_b_class == FP_ZERO);
        inf_zero = any_inf && any_zero;
        res           = {s2_sign, rnd_exp[EXP_W-1:0], rnd_frac};
        flags         = '0;
        flags.inexact = rnd_inexact;
        if (any_nan || inf_zero) begin
            res           = QNAN;
            flags         = '0;
            flags.invalid = inf_zero || any_snan;
        end else if (any_inf) begin
            res   = {s2_sign, INF_POS[W-2:0]};
            flags = '0;
        end else if (any_zero) begin
            res   = {s2_sign, {(W - 1){1'b0}}};
            flags = '0;
        end else if (rnd_exp >= EXP_MAX) begin
            res            = {s2_sign, INF_POS[W-2:0]};
            flags          = '0;
            flags.overflow = 1'b1;
            flags.inexact  = 1'b1;
        end else if (rnd_exp <= EXP_ZERO) begin
            res             = {s2_sign, {(W - 1){1'b0}}};
            flags           = '0;
            flags.underflow = 1'b1;
            flags.inexact   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (!stall) begin
            s1_valid   <= in_valid;
            s1_sign    <= in_a[W-1] ^ in_b[W-1];
            s1_a_class <= classify(a_exp, in_a[MAN_W-1:0]);
            s1_b_class <= classify(b_exp, in_b[MAN_W-1:0]);
            s1_exp     <= exp_sum;
            s1_sig_a   <= (a_exp != '0) ? {1'b1, in_a[MAN_W-1:0]} : '0;
            s1_sig_b   <= (b_exp != '0) ? {1'b1, in_b[MAN_W-1:0]} : '0;
            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_a_class <= s1_a_class;
            s2_b_class <= s1_b_class;
            s2_exp     <= s1_exp;
            s2_prod    <= P_W'(s1_sig_a) * P_W'(s1_sig_b);
            out_valid  <= s2_valid;
            out_result <= res;
            out_flags  <= flags;
        end
    end

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Self-checking bench for fp_multiplier_pipe: directed spec vectors, stall streaming,
// reset flush and randomized traffic against an integer-arithmetic reference model.
module tb_fp_multiplier_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int          n_vectors     = 0;
    int          n_miscompares = 0;
    logic [35:0] exp_q[$];
    logic        prev_stalled  = 1'b0;
    logic [35:0] prev_out;
    logic        rand_done;

    always #5 clk = ~clk;

    fp_multiplier_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic check_output(input string tag, input logic [35:0] got, input logic [35:0] want);
        n_vectors++;
        if (got !== want) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the remainder against one half.
    function automatic logic [35:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        logic s, za, zb, ia, ib, na, nb, sna, snb, inexact;
        longint unsigned p, q, r, half;
        int ea, eb, n, sh, e;
        s   = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        za  = (ea == 0);
        zb  = (eb == 0);
        ia  = (ea == 255) && (a[22:0] == 23'd0);
        ib  = (eb == 255) && (b[22:0] == 23'd0);
        na  = (ea == 255) && (a[22:0] != 23'd0);
        nb  = (eb == 255) && (b[22:0] != 23'd0);
        sna = na && !a[22];
        snb = nb && !b[22];
        if (na || nb || (ia && zb) || (ib && za))
            return {((ia && zb) || (ib && za) || sna || snb), 3'b000, 32'h7FC00000};
        if (ia || ib)
            return {4'b0000, s, 8'hFF, 23'd0};
        if (za || zb)
            return {4'b0000, s, 31'd0};
        p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        n = 63;
        while (((p >> n) & 64'd1) == 64'd0) n--;
        sh   = n - 23;
        q    = p >> sh;
        r    = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (r > half || (r == half && q[0])) q++;
        e = ea + eb - 127 + (n - 46);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        inexact = (r != 64'd0);
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0011, s, 31'd0};
        return {3'b000, inexact, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 15))
            0:       r[30:0]  = 31'd0;
            1:       r[30:0]  = {8'hFF, 23'd0};
            2:       begin r[30:23] = 8'hFF; r[0] = 1'b1; end
            3:       r[30:23] = 8'h00;
            4:       r[30:23] = 8'($urandom_range(190, 254));
            5:       r[30:23] = 8'($urandom_range(1, 60));
            default: r[30:23] = 8'($urandom_range(100, 154));
        endcase
        return r;
    endfunction

    // Scoreboard monitor: sampled on the falling edge, so it sees what the next rising edge will transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stalled = 1'b0;
        end else begin
            check_output("in_ready", 36'(in_ready), 36'(!(out_valid && !out_ready)));
            if (prev_stalled) begin
                check_output("stall_valid", 36'(out_valid), 36'd1);
                check_output("stall_hold", {out_flags, out_result}, prev_out);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check_output("unexpected_out", 36'(out_valid), 36'd0);
                else
                    check_output("result", {out_flags, out_result}, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(model_mul(in_a, in_b));
            prev_stalled = out_valid && !out_ready;
            prev_out     = {out_flags, out_result};
        end
    end

    // Called at posedge+1; returns at posedge+1 after the pair has been accepted.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check_output("accept_timeout", 36'(in_ready), 36'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] want_res, input logic [3:0] want_flags);
        int lat = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check_output({tag, "_latency"}, 36'(lat), 36'd3);
        check_output(tag, {out_flags, out_result}, {want_flags, want_res});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int drops;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        rand_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("reset_out_valid", 36'(out_valid), 36'd0);
        check_output("reset_out_result", 36'(out_result), 36'd0);
        check_output("reset_out_flags", 36'(out_flags), 36'd0);
        check_output("reset_in_ready", 36'(in_ready), 36'd1);
        @(posedge clk);
        #1;

        $display("[TB] directed vectors");
        run_directed("mul_1p5_2",    32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        run_directed("mul_neg",      32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
        run_directed("mul_inexact",  32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        run_directed("mul_overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
        run_directed("mul_underflw", 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
        run_directed("mul_inf_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        run_directed("mul_negzero",  32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
        run_directed("mul_qnan",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000);
        run_directed("mul_snan",     32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        run_directed("mul_inf_neg",  32'hFF800000, 32'hC0000000, 32'h7F800000, 4'b0000);

        $display("[TB] streaming with mid-stream stall");
        drops = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) apply_stimulus(rand_op(), rand_op());
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                repeat (12) begin
                    @(negedge clk);
                    if (!in_ready) drops++;
                end
            end
        join
        check_output("stall_in_ready_drop", 36'(drops > 0), 36'd1);
        repeat (10) @(posedge clk);
        #1;
        check_output("stream_drained", 36'(exp_q.size()), 36'd0);

        $display("[TB] reset with pairs in flight");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus(rand_op(), rand_op());
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("flush_out_valid", 36'(out_valid), 36'd0);
        check_output("flush_in_ready", 36'(in_ready), 36'd1);
        out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_output("flush_no_ghosts", 36'(seen), 36'd0);
        @(posedge clk);
        #1;

        $display("[TB] randomized traffic");
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    apply_stimulus(rand_op(), rand_op());
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_output("random_drained", 36'(exp_q.size()), 36'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
